// File: rtl/multicast_pkg.sv
// Shared helpers for the multicast fork: pointer sizing for the packet FIFO.
package multicast_pkg;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mf_fifo.sv
// Synchronous FIFO with combinational head read; push is refused when full,
// pop is ignored when empty.
module mf_fifo
  import multicast_pkg::*;
#(
  parameter int EW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [EW-1:0]              din,
  output logic [EW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [ptr_width(DEPTH):0]  count
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which
  // entries are visible, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/multicast_fork.sv
// Buffers masked packets and delivers each one to every selected output,
// retiring the head only after all selected outputs have handshaken.
module multicast_fork
  import multicast_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NOUT  = 2,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [WIDTH-1:0]  l_data,
  input  logic [NOUT-1:0]   l_mask,
  output logic [NOUT-1:0]   r_valid,
  input  logic [NOUT-1:0]   r_ready,
  output logic [WIDTH-1:0]  r_data,
  output logic [CNTW-1:0]   drop_cnt,
  output logic              busy
);

  typedef struct packed {
    logic [NOUT-1:0]  mask;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t                    wr_entry;
  entry_t                    head;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      zero_head;
  logic [ptr_width(DEPTH):0] count;
  logic [NOUT-1:0]           sent;
  logic [NOUT-1:0]           done;

  assign wr_entry = '{mask: l_mask, data: l_data};
  assign l_ready  = ~full & ~rst;
  assign push     = l_valid & l_ready;
  assign busy     = |count;

  mf_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    r_valid   = '0;
    r_data    = '0;
    zero_head = 1'b0;
    if (!empty) begin
      r_valid   = head.mask & ~sent;
      r_data    = head.data;
      zero_head = (head.mask == '0);
    end
    done = sent | (r_valid & r_ready);
    pop  = ~empty & ((head.mask & ~done) == '0);
  end

  // Outputs already served stay masked until the head retires.
  always_ff @(posedge clk) begin
    if (rst)      sent <= '0;
    else if (pop) sent <= '0;
    else          sent <= done;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 drop_cnt <= '0;
    else if (pop && zero_head && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_multicast_fork.sv
// Scoreboard bench for multicast_fork: per-output expected queues filled on
// accept, drained by a monitor on every observed output handshake.
module tb_multicast_fork;

  localparam int WIDTH = 4;
  localparam int NOUT  = 2;
  localparam int DEPTH = 2;
  localparam int CNTW  = 2;
  localparam int DROP_MAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              l_valid;
  logic              l_ready;
  logic [WIDTH-1:0]  l_data;
  logic [NOUT-1:0]   l_mask;
  logic [NOUT-1:0]   r_valid;
  logic [NOUT-1:0]   r_ready;
  logic [WIDTH-1:0]  r_data;
  logic [CNTW-1:0]   drop_cnt;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int drops    = 0;
  logic [WIDTH-1:0] exp_q [NOUT][$];

  multicast_fork #(.WIDTH(WIDTH), .NOUT(NOUT), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .l_valid  (l_valid),
    .l_ready  (l_ready),
    .l_data   (l_data),
    .l_mask   (l_mask),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int exp_drop();
    return (drops > DROP_MAX) ? DROP_MAX : drops;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NOUT; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Monitor: every handshake must match the oldest outstanding copy for that output.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < NOUT; i++) begin
        if (r_valid[i] && r_ready[i]) begin
          if (exp_q[i].size() == 0)
            check($sformatf("out%0d_extra", i), 32'(r_valid[i]), 32'd0);
          else
            check($sformatf("out%0d_data", i), 32'(r_data), 32'(exp_q[i].pop_front()));
        end
      end
    end
  end

  // Drive one packet; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [NOUT-1:0] m);
    l_valid = 1'b1;
    l_data  = d;
    l_mask  = m;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (l_ready) begin
        for (int i = 0; i < NOUT; i++) if (m[i]) exp_q[i].push_back(d);
        if (m == '0) drops++;
        @(posedge clk); #1;
        l_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'(l_ready), 32'd1);
    l_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && pending() == 0) break;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_pending", 32'(pending()), 32'd0);
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
    @(posedge clk); #1;
  endtask

  task automatic wait_cycle();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  bit rnd_on;

  initial begin
    rst = 1'b1; l_valid = 1'b0; l_data = '0; l_mask = '0; r_ready = '0;

    // Reset values
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_l_ready", 32'(l_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_l_ready", 32'(l_ready), 32'd1);
    @(posedge clk); #1;

    // Broadcast with all outputs ready: visible one cycle after accept, retires at once
    r_ready = 2'b11;
    send(4'h3, 2'b11);
    @(negedge clk);
    check("bc_r_valid", 32'(r_valid), 32'h3);
    check("bc_r_data", 32'(r_data), 32'h3);
    wait_cycle();
    check("bc_busy_fall", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Skewed readiness: out0 served once, out1 later, no repeat on out0
    r_ready = 2'b01;
    send(4'hA, 2'b11);
    @(negedge clk);
    check("skew_c1_valid", 32'(r_valid), 32'h3);
    wait_cycle();
    check("skew_c2_valid", 32'(r_valid), 32'h2);
    wait_cycle();
    check("skew_c3_valid", 32'(r_valid), 32'h2);
    @(posedge clk); #1;
    r_ready = 2'b10;
    @(negedge clk);
    check("skew_c4_valid", 32'(r_valid), 32'h2);
    wait_cycle();
    check("skew_retired", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Zero mask is dropped silently, following packet goes to out0 only
    r_ready = 2'b11;
    send(4'h5, 2'b00);
    @(negedge clk);
    check("zero_r_valid", 32'(r_valid), 32'd0);
    check("zero_r_data", 32'(r_data), 32'h5);
    @(posedge clk); #1;
    send(4'h6, 2'b01);
    drain();

    // Full FIFO stalls input; order preserved after release
    r_ready = 2'b00;
    send(4'h1, 2'b11);
    send(4'h2, 2'b11);
    l_valid = 1'b1; l_data = 4'h3; l_mask = 2'b11;
    @(negedge clk);
    check("full_l_ready", 32'(l_ready), 32'd0);
    check("full_head", 32'(r_data), 32'h1);
    wait_cycle();
    check("full_l_ready_hold", 32'(l_ready), 32'd0);
    @(posedge clk); #1;
    r_ready = 2'b11;
    send(4'h3, 2'b11);
    drain();

    // Drop counter saturates
    for (int k = 0; k < 5; k++) send(4'(k), 2'b00);
    drain();

    // Reset while the head is half delivered
    r_ready = 2'b01;
    send(4'h9, 2'b11);
    wait_cycle();
    check("half_r_valid", 32'(r_valid), 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    r_ready = 2'b00;
    for (int i = 0; i < NOUT; i++) exp_q[i].delete();
    drops = 0;
    wait_cycle();
    check("mid_rst_r_valid", 32'(r_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_l_ready", 32'(l_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_r_valid_after", 32'(r_valid), 32'd0);
    @(posedge clk); #1;
    r_ready = 2'b11;
    send(4'hC, 2'b11);
    drain();

    // Randomised traffic with random per-cycle readiness
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          send(4'($urandom), 2'($urandom));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          r_ready = 2'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    r_ready = 2'b11;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicast_fork.md
# multicast_fork

Clocked, parametrised successor to the two-way CSP copy element: accepts one WIDTH-bit packet plus a NOUT-bit destination mask on a valid/ready input, buffers it in a DEPTH-entry FIFO, and delivers the same packet to every output whose mask bit is set. Each output completes its own handshake independently; the head packet retires only once all selected outputs have taken it. It sits between a PE's result path and the neighbouring routers/PEs that need copies of the same packet.

## Interface

- WIDTH, 4, packet data width in bits
- NOUT, 2, number of output channels (≥2)
- DEPTH, 2, input FIFO entries (power of two, ≥2)
- CNTW, 8, width of the dropped-packet counter

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- l_valid  input  1  input packet valid
- l_ready  output  1  input can accept
- l_data  input  WIDTH  input packet
- l_mask  input  NOUT  destination mask; bit i selects output i
- r_valid  output  NOUT  per-output valid
- r_ready  input  NOUT  per-output ready
- r_data  output  WIDTH  head packet, shared by all outputs
- drop_cnt  output  CNTW  packets retired with an all-zero mask, saturating
- busy  output  1  FIFO non-empty

## Operation

- Storage: FIFO of {mask, data}, DEPTH entries, read/write pointers plus occupancy count (0..DEPTH).
- Input accept: l_valid & l_ready writes {l_mask, l_data} at tail. l_ready = (count < DEPTH) & ~rst; independent of l_valid and of pops in the same cycle (no full-bypass).
- Per-head register sent[NOUT]: outputs that have already taken the current head.
- r_valid[i] = ~empty & head_mask[i] & ~sent[i]; r_data = head_data when non-empty, else 0. r_valid never depends on r_ready.
- Each cycle: done = sent | (r_valid & r_ready). If (head_mask & ~done) == 0 and non-empty → pop head, sent ← 0; else sent ← done.
- Zero-mask head: pops the cycle it becomes head, no r_valid asserted, drop_cnt increments (holds at 2^CNTW−1).
- Simultaneous push and pop: count unchanged, both pointers advance; legal at full only in the sense that pop occurs, push is refused (l_ready was 0).
- Pointer wrap: modulo DEPTH.
- Reset: count, pointers, sent, drop_cnt ← 0. Mid-operation reset discards all buffered packets and partially delivered heads; no output re-delivers after reset.

## Timing

- Reset values (after first edge with rst high): l_ready=0 while rst high, 1 the first cycle after rst low; r_valid=0; r_data=0; drop_cnt=0; busy=0.
- Latency: packet accepted at edge N appears on r_valid at cycle N+1 (empty FIFO); no combinational input→output path.
- Throughput: one packet per cycle when every selected output is ready each cycle.
- Partial delivery: an output that handshakes stays deasserted for that head; slow outputs never cause duplicates on fast ones.
- Input stalls only when count == DEPTH.

## Structure

- Package multicast_pkg: function computing pointer width ($clog2(DEPTH)), typedef for the {mask,data} FIFO entry parameterised via localparams in the module.
- One sub-module: mf_fifo (sync FIFO, synchronous active-high reset, push/pop/full/empty/count, head read combinational from storage).
- Top: sent register, retire logic, drop counter; ~150–250 lines total.

## Test plan

- NOUT=2, all r_ready=1: send 0x3 mask 2'b11 → both r_valid at N+1 with r_data=0x3, pop same cycle, busy falls next cycle.
- Skewed readiness: send 0xA mask 11, r_ready=2'b01 for 3 cycles then 2'b10 → out0 takes once, r_valid[0] drops, out1 takes at cycle 4, head retires, no duplicate on out0.
- Zero mask: send 0x5 mask 00 then 0x6 mask 01 → no r_valid for 0x5, drop_cnt=1, 0x6 delivered on out0 only.
- Full: r_ready=0, push 3 packets DEPTH=2 → l_ready=0 after 2, third held; release ready → order preserved 1,2,3.
- Saturation: CNTW=2, five zero-mask packets → drop_cnt stops at 3.
- Reset mid-delivery: head half-sent (sent=01), assert rst one cycle → r_valid=0, busy=0, drop_cnt=0; after release, new packet delivered normally to both outputs.
